multicycle_control: RTL and testbench

- Main control FSM for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and write-back over several clocks.
- Drives the 2-bit ALUOp consumed by ALUControl, plus all datapath mux selects and write enables.
- Stalls on a memory-ready handshake and counts retired instructions.

---
 rtl/mips_ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_control_retire_counter.sv | 23 ++
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALUOp,
// mux selects, FSM state numbers and the bundled control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam int unsigned ST_FETCH   = 0;
  localparam int unsigned ST_DECODE  = 1;
  localparam int unsigned ST_MEMADDR = 2;
  localparam int unsigned ST_MEMRD   = 3;
  localparam int unsigned ST_MEMWB   = 4;
  localparam int unsigned ST_MEMWR   = 5;
  localparam int unsigned ST_RTEXEC  = 6;
  localparam int unsigned ST_RTWB    = 7;
  localparam int unsigned ST_BRANCH  = 8;
  localparam int unsigned ST_JUMP    = 9;
  localparam int unsigned ST_IMMEXEC = 10;
  localparam int unsigned ST_IMMWB   = 11;
  localparam int unsigned ST_TRAP    = 12;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Retired-instruction counter: free-running wrap, synchronous clear.
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM (Moore, mem_ready-qualified fetch/memory).
// Define ILLEGAL_TRAP_EN to add the trap port and the sticky TRAP state.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Op,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               PCWriteCondNe,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtZero,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic [CNT_W-1:0]   retired,
  output logic [STATE_W-1:0] state_dbg
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic               trap
`endif
);

  localparam logic [STATE_W-1:0] S_FETCH   = STATE_W'(ST_FETCH);
  localparam logic [STATE_W-1:0] S_DECODE  = STATE_W'(ST_DECODE);
  localparam logic [STATE_W-1:0] S_MEMADDR = STATE_W'(ST_MEMADDR);
  localparam logic [STATE_W-1:0] S_MEMRD   = STATE_W'(ST_MEMRD);
  localparam logic [STATE_W-1:0] S_MEMWB   = STATE_W'(ST_MEMWB);
  localparam logic [STATE_W-1:0] S_MEMWR   = STATE_W'(ST_MEMWR);
  localparam logic [STATE_W-1:0] S_RTEXEC  = STATE_W'(ST_RTEXEC);
  localparam logic [STATE_W-1:0] S_RTWB    = STATE_W'(ST_RTWB);
  localparam logic [STATE_W-1:0] S_BRANCH  = STATE_W'(ST_BRANCH);
  localparam logic [STATE_W-1:0] S_JUMP    = STATE_W'(ST_JUMP);
  localparam logic [STATE_W-1:0] S_IMMEXEC = STATE_W'(ST_IMMEXEC);
  localparam logic [STATE_W-1:0] S_IMMWB   = STATE_W'(ST_IMMWB);
`ifdef ILLEGAL_TRAP_EN
  localparam logic [STATE_W-1:0] S_TRAP    = STATE_W'(ST_TRAP);
`endif

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic               w_retire;
  ctrl_t              w_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; w_retire marks the final cycle of a supported instruction.
  always_comb begin
    w_next   = S_FETCH;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW:     w_next = S_MEMADDR;
          OP_RTYPE:         w_next = S_RTEXEC;
          OP_BEQ, OP_BNE:   w_next = S_BRANCH;
          OP_J:             w_next = S_JUMP;
          OP_ADDI, OP_ANDI: w_next = S_IMMEXEC;
`ifdef ILLEGAL_TRAP_EN
          default:          w_next = S_TRAP;
`else
          default:          w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADDR: w_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        w_next   = mem_ready ? S_FETCH : S_MEMWR;
        w_retire = mem_ready;
      end
      S_RTEXEC:  w_next = S_RTWB;
      S_IMMEXEC: w_next = S_IMMWB;
      S_MEMWB, S_RTWB, S_BRANCH, S_JUMP, S_IMMWB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:    w_next = S_TRAP;
`endif
      default:   w_next = S_FETCH;
    endcase
  end

  // Moore decode; reset overrides everything so no write leaks while held.
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.ir_write  = mem_ready;
        w_ctrl.pc_write  = mem_ready;
      end
      S_DECODE:  w_ctrl.alu_src_b = SRCB_IMMSH;
      S_MEMADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
      end
      S_RTEXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_RT;
        w_ctrl.alu_op    = ALU_FUNCT;
      end
      S_RTWB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a        = 1'b1;
        w_ctrl.alu_src_b        = SRCB_RT;
        w_ctrl.alu_op           = ALU_SUB;
        w_ctrl.pc_source        = PCSRC_ALUOUT;
        w_ctrl.pc_write_cond    = (Op == OP_BEQ);
        w_ctrl.pc_write_cond_ne = (Op == OP_BNE);
      end
      S_JUMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_JUMP;
      end
      S_IMMEXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        if (Op == OP_ANDI) begin
          w_ctrl.alu_op   = ALU_AND;
          w_ctrl.ext_zero = 1'b1;
        end else begin
          w_ctrl.alu_op   = ALU_ADD;
        end
      end
      S_IMMWB:   w_ctrl.reg_write = 1'b1;
      default:   w_ctrl = '0;
    endcase
    if (reset) begin
      w_ctrl = '0;
    end
  end

  retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_inc   (w_retire),
    .o_count (retired)
  );

  assign PCWrite       = w_ctrl.pc_write;
  assign PCWriteCond   = w_ctrl.pc_write_cond;
  assign PCWriteCondNe = w_ctrl.pc_write_cond_ne;
  assign IorD          = w_ctrl.i_or_d;
  assign MemRead       = w_ctrl.mem_read;
  assign MemWrite      = w_ctrl.mem_write;
  assign IRWrite       = w_ctrl.ir_write;
  assign MemtoReg      = w_ctrl.mem_to_reg;
  assign RegDst        = w_ctrl.reg_dst;
  assign RegWrite      = w_ctrl.reg_write;
  assign ALUSrcA       = w_ctrl.alu_src_a;
  assign ALUSrcB       = w_ctrl.alu_src_b;
  assign ExtZero       = w_ctrl.ext_zero;
  assign PCSource      = w_ctrl.pc_source;
  assign ALUOp         = w_ctrl.alu_op;
  assign state_dbg     = r_state;
`ifdef ILLEGAL_TRAP_EN
  assign trap          = (r_state == S_TRAP) && !reset;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level driver pushes
// the expected per-cycle state/controls/retire count; a monitor pops and checks.
module tb_multicycle_control;

  localparam int STATE_W = 4;
  localparam int CNT_W   = 4;

  localparam int FETCH = 0, DECODE = 1, MEMADDR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
  localparam int RTEXEC = 6, RTWB = 7, BRANCH = 8, JUMP = 9, IMMEXEC = 10, IMMWB = 11;
  localparam int TRAPST = 12;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, JMP = 6'b000010, ADDI = 6'b001000, ANDI = 6'b001100;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [5:0]         Op = 6'd0;
  logic               mem_ready = 1'b0;
  logic               PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite;
  logic               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ExtZero;
  logic [1:0]         ALUSrcB, PCSource, ALUOp;
  logic [CNT_W-1:0]   retired;
  logic [STATE_W-1:0] state_dbg;
  logic               tb_trap;

  multicycle_control #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtZero(ExtZero), .PCSource(PCSource), .ALUOp(ALUOp),
    .retired(retired), .state_dbg(state_dbg)
`ifdef ILLEGAL_TRAP_EN
    , .trap(tb_trap)
`endif
  );
`ifndef ILLEGAL_TRAP_EN
  assign tb_trap = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, pcwc, pcwcn, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
    logic [1:0] srcb;
    logic ext;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic trap;
  } ctl_t;

  typedef struct {
    int               st;
    bit               known;
    ctl_t             ctl;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t             q[$];
  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  // Expected controls for one cycle, straight from the per-state output table.
  function automatic ctl_t exp_ctl(input int st, input logic [5:0] op, input logic mr);
    ctl_t c;
    c = '0;
    case (st)
      FETCH:   begin c.mrd = 1; c.srcb = 2'b01; c.irw = mr; c.pcw = mr; end
      DECODE:  c.srcb = 2'b11;
      MEMADDR: begin c.srca = 1; c.srcb = 2'b10; end
      MEMRD:   begin c.mrd = 1; c.iord = 1; end
      MEMWB:   begin c.rwr = 1; c.m2r = 1; end
      MEMWR:   begin c.mwr = 1; c.iord = 1; end
      RTEXEC:  begin c.srca = 1; c.aluop = 2'b10; end
      RTWB:    begin c.rwr = 1; c.rdst = 1; end
      BRANCH:  begin
        c.srca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01;
        c.pcwc = (op == BEQ); c.pcwcn = (op == BNE);
      end
      JUMP:    begin c.pcw = 1; c.pcsrc = 2'b10; end
      IMMEXEC: begin
        c.srca = 1; c.srcb = 2'b10;
        if (op == ANDI) begin c.aluop = 2'b11; c.ext = 1; end
      end
      IMMWB:   c.rwr = 1;
      TRAPST:  c.trap = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input int s, input logic mr, input logic [5:0] op);
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    Op = op;
    mem_ready = mr;
    e.st = s; e.known = 1; e.ctl = exp_ctl(s, op, mr); e.ret = exp_ret;
    q.push_back(e);
  endtask

  task automatic step_rst(input int s, input bit known);
    exp_t e;
    @(negedge clk);
    reset = 1'b1;
    mem_ready = rnd();
    e.st = s; e.known = known; e.ctl = '0; e.ret = exp_ret;
    q.push_back(e);
  endtask

  task automatic retire();
    exp_ret = exp_ret + 1'b1;
  endtask

  // One instruction as a sequence of phases, with fst fetch stalls and mst memory stalls.
  task automatic run_instr(input logic [5:0] op, input int fst, input int mst);
    repeat (fst) step(FETCH, 1'b0, op);
    step(FETCH, 1'b1, op);
    step(DECODE, rnd(), op);
    case (op)
      LW: begin
        step(MEMADDR, rnd(), op);
        repeat (mst) step(MEMRD, 1'b0, op);
        step(MEMRD, 1'b1, op);
        step(MEMWB, rnd(), op);
        retire();
      end
      SW: begin
        step(MEMADDR, rnd(), op);
        repeat (mst) step(MEMWR, 1'b0, op);
        step(MEMWR, 1'b1, op);
        retire();
      end
      RT: begin
        step(RTEXEC, rnd(), op);
        step(RTWB, rnd(), op);
        retire();
      end
      BEQ, BNE: begin
        step(BRANCH, rnd(), op);
        retire();
      end
      JMP: begin
        step(JUMP, rnd(), op);
        retire();
      end
      ADDI, ANDI: begin
        step(IMMEXEC, rnd(), op);
        step(IMMWB, rnd(), op);
        retire();
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        repeat (4) step(TRAPST, rnd(), op);
`endif
      end
    endcase
  endtask

  // Monitor: one expected record per cycle, checked mid-cycle.
  initial begin
    exp_t e;
    ctl_t a;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ExtZero, PCSource, ALUOp, tb_trap};
        checks++;
        if (a !== e.ctl) begin
          errors++;
          $display("FAIL ctl @%0t state=%0d: got %b want %b", $time, e.st, a, e.ctl);
        end
        if (e.known) begin
          checks++;
          if (state_dbg !== STATE_W'(e.st)) begin
            errors++;
            $display("FAIL state @%0t: got %0d want %0d", $time, state_dbg, e.st);
          end
          checks++;
          if (retired !== e.ret) begin
            errors++;
            $display("FAIL retired @%0t: got %0d want %0d", $time, retired, e.ret);
          end
        end
      end
    end
  end

  initial begin
    logic [5:0] ops[$];
    ops = '{RT, LW, SW, BEQ, BNE, JMP, ADDI, ANDI};
`ifndef ILLEGAL_TRAP_EN
    ops.push_back(6'b111111);
    ops.push_back(6'b010000);
`endif
    step_rst(FETCH, 0);
    exp_ret = '0;
    step_rst(FETCH, 1);

    run_instr(RT, 0, 0);
    run_instr(LW, 0, 2);
    run_instr(BNE, 0, 0);
    run_instr(BEQ, 1, 0);
    run_instr(ANDI, 0, 0);
    run_instr(ADDI, 2, 0);
    run_instr(JMP, 0, 0);
    run_instr(SW, 0, 1);
`ifndef ILLEGAL_TRAP_EN
    run_instr(6'b111111, 0, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      run_instr(ops[$urandom_range(0, ops.size() - 1)], $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset while a store is stalled in MEMWR.
    step(FETCH, 1'b1, SW);
    step(DECODE, 1'b1, SW);
    step(MEMADDR, 1'b1, SW);
    step(MEMWR, 1'b0, SW);
    step(MEMWR, 1'b0, SW);
    step_rst(MEMWR, 1);
    exp_ret = '0;
    run_instr(RT, 0, 0);

`ifdef ILLEGAL_TRAP_EN
    run_instr(6'b111111, 0, 0);
    step_rst(TRAPST, 1);
    exp_ret = '0;
    run_instr(ADDI, 0, 0);
`endif

    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
